trap_csr_unit: RTL and testbench

//  Consumes trap/mcause/mepc/mbadaddr from interrupt_ctrl and owns the machine trap CSRs.

---
 rtl/trap_csr_unit.sv | 192 +++++++++++++++++++
 tb/tb_trap_csr_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/trap_csr_unit.sv
// trap_csr_unit
//   Owns the machine trap CSRs (mstatus, mie, mtvec, mepc, mcause, mtval, mip).
//   Arbitrates synchronous traps, pending interrupts and mret while idle.
//   Saves trap state and updates mstatus.MIE/MPIE.
//   Drives a held redirect (trap vector or mepc) to fetch until fetch acks it.
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   trap_req/cause/epc/badaddr  synchronous trap from interrupt_ctrl
//   pc_in                    next PC, saved as mepc when an interrupt is taken
//   mret                     mret retiring this cycle
//   irq_ext/timer/soft       raw interrupt lines (mip bits 11/7/3)
//   csr_we/addr/wdata/rdata  core CSR port; rdata is combinational, 0 if unmapped
//   mstatus_o, mie_o         current CSR values
//   redirect_valid/pc/ack    redirect to fetch (valid/ready: see below)
//   flush                    one-cycle squash pulse (SAVE and RETURN)
//   busy                     high whenever the FSM is not IDLE
//   state_dbg                current FSM state encoding
// Handshake: redirect_valid rises with redirect_pc and both hold steady until
// a cycle in which redirect_ack is high; at that clock edge the redirect is
// consumed. redirect_ack while redirect_valid is low is ignored.
module trap_csr_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_epc,
  input  logic [31:0] trap_badaddr,
  input  logic [31:0] pc_in,
  input  logic        mret,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_soft,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic [31:0] mstatus_o,
  output logic [31:0] mie_o,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ack,
  output logic        flush,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SAVE     = 3'd1,
    S_VECTOR   = 3'd2,
    S_RETURN   = 3'd3,
    S_WAIT_ACK = 3'd4
  } state_t;

  // Bit 0 (mode) only survives when vectored mode is supported.
  localparam logic [31:0] MTVEC_MASK = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

  state_t      state, state_n;
  logic        st_mie, st_mpie;
  logic [31:0] mie_r, mtvec_r, mepc_r, mcause_r, mtval_r;
  logic [31:0] cause_q, epc_q, badaddr_q;
  logic [31:0] mip_w, pend, vec_target;
  logic        irq_take;
  logic [4:0]  irq_code;

  assign mip_w     = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_soft, 3'b0};
  assign pend      = mie_r & mip_w;
  assign irq_take  = st_mie & (|pend);
  // External beats software beats timer.
  assign irq_code  = pend[11] ? 5'd11 : (pend[3] ? 5'd3 : 5'd7);

  // MPP is hardwired to machine mode.
  assign mstatus_o = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
  assign mie_o     = mie_r;

  // Target is computed from the latched cause during SAVE, so it matches the
  // mcause value that becomes visible in VECTOR.
  always_comb begin
    vec_target = {mtvec_r[31:2], 2'b00};
    if (mtvec_r[0] && cause_q[31])
      vec_target = {mtvec_r[31:2], 2'b00} + {25'b0, cause_q[4:0], 2'b00};
  end

  always_comb begin
    csr_rdata = 32'b0;
    case (csr_addr)
      12'h300: csr_rdata = mstatus_o;
      12'h304: csr_rdata = mie_r;
      12'h305: csr_rdata = mtvec_r;
      12'h341: csr_rdata = mepc_r;
      12'h342: csr_rdata = mcause_r;
      12'h343: csr_rdata = mtval_r;
      12'h344: csr_rdata = mip_w;
      default: csr_rdata = 32'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (trap_req || irq_take) state_n = S_SAVE;
        else if (mret)            state_n = S_RETURN;
      end
      S_SAVE:                 state_n = S_VECTOR;
      S_VECTOR, S_RETURN,
      S_WAIT_ACK:             state_n = redirect_ack ? S_IDLE : S_WAIT_ACK;
      default:                state_n = S_IDLE;
    endcase
  end

  assign flush     = (state == S_SAVE) || (state == S_RETURN);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
    end else begin
      state          <= state_n;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_mie         <= 1'b0;
      st_mpie        <= 1'b0;
      mie_r          <= 32'b0;
      mtvec_r        <= RESET_MTVEC & MTVEC_MASK;
      mepc_r         <= 32'b0;
      mcause_r       <= 32'b0;
      mtval_r        <= 32'b0;
      cause_q        <= 32'b0;
      epc_q          <= 32'b0;
      badaddr_q      <= 32'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trap_req) begin
            cause_q   <= trap_cause;
            epc_q     <= trap_epc;
            badaddr_q <= trap_badaddr;
          end else if (irq_take) begin
            cause_q   <= {1'b1, 26'b0, irq_code};
            epc_q     <= pc_in;
            badaddr_q <= 32'b0;
          end else if (mret) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= mepc_r;
          end else if (csr_we) begin
            case (csr_addr)
              12'h300: begin
                st_mie  <= csr_wdata[3];
                st_mpie <= csr_wdata[7];
              end
              12'h304: mie_r    <= csr_wdata & 32'h0000_0888;
              12'h305: mtvec_r  <= csr_wdata & MTVEC_MASK;
              12'h341: mepc_r   <= csr_wdata & 32'hFFFF_FFFC;
              12'h342: mcause_r <= csr_wdata;
              12'h343: mtval_r  <= csr_wdata;
              default: ;
            endcase
          end
        end
        S_SAVE: begin
          mepc_r         <= epc_q & 32'hFFFF_FFFC;
          mcause_r       <= cause_q;
          mtval_r        <= badaddr_q;
          st_mpie        <= st_mie;
          st_mie         <= 1'b0;
          redirect_valid <= 1'b1;
          redirect_pc    <= vec_target;
        end
        S_RETURN: begin
          st_mie  <= st_mpie;
          st_mpie <= 1'b1;
          if (redirect_ack) redirect_valid <= 1'b0;
        end
        S_VECTOR, S_WAIT_ACK: begin
          if (redirect_ack) redirect_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_csr_unit.sv
module tb_trap_csr_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        trap_req;
  logic [31:0] trap_cause, trap_epc, trap_badaddr, pc_in;
  logic        mret, irq_ext, irq_timer, irq_soft;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, mstatus_o, mie_o, redirect_pc;
  logic        redirect_valid, redirect_ack, flush, busy;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  trap_csr_unit dut (
    .clk(clk), .resetn(resetn),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_epc(trap_epc),
    .trap_badaddr(trap_badaddr), .pc_in(pc_in), .mret(mret),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .mstatus_o(mstatus_o), .mie_o(mie_o),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ack(redirect_ack), .flush(flush), .busy(busy),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // checking
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // drivers: inputs change at negedge, outputs sampled at negedge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic trap(input logic [31:0] c, input logic [31:0] e, input logic [31:0] b);
    trap_req = 1'b1; trap_cause = c; trap_epc = e; trap_badaddr = b;
    tick();
    trap_req = 1'b0;
  endtask

  task automatic ack();
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; trap_req = 0; trap_cause = 0; trap_epc = 0; trap_badaddr = 0;
    pc_in = 0; mret = 0; irq_ext = 0; irq_timer = 0; irq_soft = 0;
    csr_we = 0; csr_addr = 0; csr_wdata = 0; redirect_ack = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // reset state
    chk("rst_valid", {31'b0, redirect_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_flush", {31'b0, flush}, 32'd0);
    chk("rst_mstatus", mstatus_o, 32'h0000_1800);
    rd_chk("rst_mtvec", 12'h305, 32'h0000_0100);

    // 1: synchronous trap to non-vectored mtvec
    csr_wr(12'h300, 32'h0000_0008);
    chk("t1_mstatus_pre", mstatus_o, 32'h0000_1808);
    trap(32'd4, 32'h2002, 32'h2002);
    chk("t1_save_flush", {31'b0, flush}, 32'd1);
    chk("t1_save_busy", {31'b0, busy}, 32'd1);
    chk("t1_save_valid", {31'b0, redirect_valid}, 32'd0);
    tick();
    chk("t1_vec_valid", {31'b0, redirect_valid}, 32'd1);
    chk("t1_vec_pc", redirect_pc, 32'h0000_0100);
    chk("t1_vec_flush", {31'b0, flush}, 32'd0);
    rd_chk("t1_mepc", 12'h341, 32'h0000_2000);
    rd_chk("t1_mcause", 12'h342, 32'd4);
    rd_chk("t1_mtval", 12'h343, 32'h0000_2002);
    chk("t1_mstatus", mstatus_o, 32'h0000_1880);
    tick(); tick();
    chk("t1_hold_state", {29'b0, state_dbg}, 32'd4);
    chk("t1_hold_valid", {31'b0, redirect_valid}, 32'd1);
    chk("t1_hold_pc", redirect_pc, 32'h0000_0100);
    ack();
    chk("t1_ack_valid", {31'b0, redirect_valid}, 32'd0);
    chk("t1_ack_busy", {31'b0, busy}, 32'd0);

    // 4: mret back to mepc
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk("t4_ret_valid", {31'b0, redirect_valid}, 32'd1);
    chk("t4_ret_pc", redirect_pc, 32'h0000_2000);
    chk("t4_ret_flush", {31'b0, flush}, 32'd1);
    tick();
    chk("t4_wait_flush", {31'b0, flush}, 32'd0);
    chk("t4_mstatus", mstatus_o, 32'h0000_1888);
    chk("t4_wait_pc", redirect_pc, 32'h0000_2000);
    ack();
    chk("t4_ack_valid", {31'b0, redirect_valid}, 32'd0);

    // 5: write masks, writes ignored while busy, read-only mip
    csr_wr(12'h305, 32'hFFFF_FFFF);
    rd_chk("t5_mtvec", 12'h305, 32'hFFFF_FFFD);
    csr_wr(12'h304, 32'hFFFF_FFFF);
    rd_chk("t5_mie", 12'h304, 32'h0000_0888);
    csr_wr(12'h304, 32'h0);
    csr_wr(12'h341, 32'h0000_1237);
    rd_chk("t5_mepc", 12'h341, 32'h0000_1234);
    rd_chk("t5_unmapped", 12'h7C0, 32'h0);
    trap(32'd2, 32'h300, 32'h0);
    tick(); tick();
    chk("t5_vec_pc", redirect_pc, 32'hFFFF_FFFC);
    csr_wr(12'h343, 32'h0000_DEAD);
    rd_chk("t5_busy_write", 12'h343, 32'h0);
    chk("t5_busy_state", {29'b0, state_dbg}, 32'd4);
    ack();
    irq_soft = 1'b1;
    csr_wr(12'h344, 32'h0);
    rd_chk("t5_mip", 12'h344, 32'h0000_0008);
    irq_soft = 1'b0;
    #1;
    rd_chk("t5_mip_live", 12'h344, 32'h0);

    // 2: vectored timer interrupt
    csr_wr(12'h305, 32'h0000_0201);
    csr_wr(12'h304, 32'h0000_0080);
    csr_wr(12'h300, 32'h0000_0008);
    pc_in = 32'h40; irq_timer = 1'b1;
    tick();
    irq_timer = 1'b0;
    chk("t2_save_state", {29'b0, state_dbg}, 32'd1);
    tick();
    rd_chk("t2_mcause", 12'h342, 32'h8000_0007);
    rd_chk("t2_mepc", 12'h341, 32'h0000_0040);
    rd_chk("t2_mtval", 12'h343, 32'h0);
    chk("t2_pc", redirect_pc, 32'h0000_021C);
    ack();  // same cycle valid is raised
    chk("t2_same_ack_valid", {31'b0, redirect_valid}, 32'd0);
    chk("t2_same_ack_busy", {31'b0, busy}, 32'd0);

    // 3: trap beats simultaneous interrupts; interrupt taken after mret
    csr_wr(12'h304, 32'h0000_0880);
    csr_wr(12'h300, 32'h0000_0008);
    irq_ext = 1'b1; irq_timer = 1'b1; pc_in = 32'h600;
    trap(32'd2, 32'h500, 32'h77);
    tick();
    rd_chk("t3_mcause", 12'h342, 32'd2);
    rd_chk("t3_mepc", 12'h341, 32'h0000_0500);
    rd_chk("t3_mtval", 12'h343, 32'h0000_0077);
    chk("t3_pc", redirect_pc, 32'h0000_0200);
    ack();
    chk("t3_idle_masked", {29'b0, state_dbg}, 32'd0);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    ack();  // accepted in RETURN
    chk("t3_ret_mstatus", mstatus_o, 32'h0000_1888);
    tick();
    irq_ext = 1'b0; irq_timer = 1'b0;
    chk("t3_irq_state", {29'b0, state_dbg}, 32'd1);
    tick();
    rd_chk("t3_irq_mcause", 12'h342, 32'h8000_000B);
    rd_chk("t3_irq_mepc", 12'h341, 32'h0000_0600);
    chk("t3_irq_pc", redirect_pc, 32'h0000_022C);
    ack();

    // 6: reset while waiting for ack
    trap(32'd1, 32'h900, 32'h904);
    tick(); tick();
    chk("t6_pre_valid", {31'b0, redirect_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_valid", {31'b0, redirect_valid}, 32'd0);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_pc", redirect_pc, 32'h0);
    chk("t6_mstatus", mstatus_o, 32'h0000_1800);
    rd_chk("t6_mie", 12'h304, 32'h0);
    rd_chk("t6_mtvec", 12'h305, 32'h0000_0100);
    rd_chk("t6_mepc", 12'h341, 32'h0);
    rd_chk("t6_mcause", 12'h342, 32'h0);
    rd_chk("t6_mtval", 12'h343, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("t6_after_state", {29'b0, state_dbg}, 32'd0);

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
